mystic_main_mem_tx: RTL and testbench
=====================================

// Module: mystic_main_mem_tx
// PURPOSE
//  UART memory-dump transmitter; counterpart of the UART main-memory loader.
//  On start_i: holds the core in reset, sends the 4-byte HEADER, then streams
//  len_i bytes read from main memory starting at base_addr_i, as 8N1 frames on tx_o.
//  Contains its own bit serializer. Sits beside the loader on the memory's second port.
// PARAMETERS
//  HEADER  32'hABCD1234  sync word, sent MSB byte first
//  ADDR_W  18            memory byte-address width
// PORTS
//  clk_i           in   1       system clock
//  rst_i           in   1       synchronous, active-high reset
//  start_i         in   1       1-cycle start pulse; ignored while busy_o=1
//  base_addr_i     in   ADDR_W  first byte address; sampled with start_i
//  len_i           in   ADDR_W  byte count, 0 allowed; sampled with start_i
//  baud_div        in   16      clk cycles per bit (clkfreq/baudrate); 0 treated as 1
//  mem_din_i       in   8       read data; valid 1 cycle after mem_re_o
//  mem_addr_o      out  ADDR_W  read address
//  mem_re_o        out  1       read strobe, 1 cycle per byte
//  tx_o            out  1       serial out, idle high
//  disable_core_n  out  1       active low; 0 for the whole transfer
//  busy_o          out  1       transfer in progress
//  done_o          out  1       1-cycle pulse after the final stop bit
// BEHAVIOUR
//  Reset values: tx_o=1, disable_core_n=1, busy_o=0, done_o=0, mem_re_o=0, mem_addr_o=0.
//  Reset mid-transfer aborts the transfer; tx_o is 1 from the next edge on.
//  States: S_IDLE -> S_HDR -> S_DATA -> S_DONE -> S_IDLE.
//  S_IDLE: start_i=1 latches base/len, resets byte counter -> S_HDR.
//   From the next cycle: busy_o=1, disable_core_n=0, tx_o=0 (first start bit).
//  Frame: start bit 0, data LSB first, stop bit 1. Each bit is baud_div cycles
//   (1 if baud_div=0). A frame is 10*baud_div cycles.
//  baud_div is sampled at each frame start; changing it mid-frame has no effect.
//  Frames are back-to-back, with no idle cycles between bytes.
//   A transfer lasts exactly (4+len)*10*baud_div cycles.
//  S_HDR: sends HEADER[31:24], [23:16], [15:8], [7:0].
//   During the last header frame, issue the read for byte 0 (when len>0).
//  S_DATA: while sending byte n, issue mem_re_o for byte n+1 (if n+1 < len).
//   Capture mem_din_i the cycle after mem_re_o into a 1-byte prefetch register.
//  Address: mem_addr_o = base + n, wraps modulo 2**ADDR_W (no error).
//  Stop after len data frames. len=0: header only, mem_re_o never asserts.
//  S_DONE: one cycle. done_o=1, busy_o=0, disable_core_n=1 -> S_IDLE.
//   start_i in this cycle is ignored; start is accepted from the next cycle.
//  start_i while busy_o=1: ignored, with no effect on the current transfer.
//  Byte counter width is ADDR_W+1, so len up to 2**ADDR_W-1 does not overflow.
// TESTING
//  T1: baud_div=4, base=0x10, len=2, mem[0x10]=0x55, mem[0x11]=0xA3
//   -> tx bytes AB,CD,12,34,55,A3; 240 cycles; done_o 1 pulse; disable_core_n=0 throughout.
//  T2: len=0, baud_div=2 -> only the header (80 cycles); mem_re_o stays 0; done_o pulse.
//  T3: base=0x3FFFF, len=3 -> mem_addr_o 0x3FFFF, 0x00000, 0x00001; bytes correct.
//  T4: start_i pulsed again mid-T1 with base=0x0
//   -> ignored; output identical to T1.
//  T5: rst_i asserted mid data frame -> next edge tx_o=1, busy_o=0,
//   disable_core_n=1; a new start then sends a full header.
//  T6: baud_div=0 and baud_div=1 -> 1 cycle/bit; 10-cycle frames, no gaps (checker decodes).

Source files
------------

// File: rtl/mystic_main_mem_tx.sv
// UART memory-dump transmitter: sends a 4-byte sync header, then len_i bytes read from main memory, as 8N1 frames.
// Latency: the first start bit appears the cycle after start_i; the transfer lasts (4+len)*10*baud_div cycles, then done_o pulses once.
// Backpressure: none. Frames run back-to-back; start_i is ignored while busy_o=1 and during the done cycle.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                1-cycle start pulse (base_addr_i/len_i sampled with it)
//   baud_div               clk cycles per bit, 0 treated as 1, sampled per frame
//   mem_addr_o/mem_re_o    read port, data returns on mem_din_i one cycle later
//   tx_o                   serial output, idle high
//   disable_core_n         low while the transfer runs
//   busy_o, done_o         transfer in progress / 1-cycle completion pulse
module mystic_main_mem_tx #(
    parameter logic [31:0] HEADER = 32'hABCD1234,
    parameter int          ADDR_W = 18
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic [15:0]       baud_div,
    input  logic [7:0]        mem_din_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              tx_o,
    output logic              disable_core_n,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_TWO = {{(ADDR_W-1){1'b0}}, 2'b10};

    logic [1:0]        state_q, state_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;   // index of the data byte on the wire
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [15:0]       div_q, div_d;             // bit period latched at frame start
    logic [15:0]       baud_cnt_q, baud_cnt_d;
    logic [3:0]        bit_idx_q, bit_idx_d;     // 0 = start bit, 9 = stop bit
    logic [8:0]        shift_q, shift_d;         // {stop, data} still to be sent
    logic              tx_q, tx_d;
    logic [7:0]        pre_q, pre_d;             // prefetched next data byte
    logic              re_q, re_d;
    logic              re_dly_q, re_dly_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              frame_end;
    logic              load;
    logic [7:0]        load_byte;
    logic              issue_rd;
    logic [ADDR_W:0]   rd_idx;
    logic [15:0]       eff_div;
    logic [ADDR_W:0]   len_ext;
    logic [ADDR_W:0]   cnt_p1;
    logic [ADDR_W:0]   cnt_p2;
    logic [1:0]        hdr_nxt;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = HEADER[31:24];
            2'd1:    b = HEADER[23:16];
            2'd2:    b = HEADER[15:8];
            default: b = HEADER[7:0];
        endcase
        return b;
    endfunction

    assign eff_div   = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign len_ext   = {1'b0, len_q};
    assign cnt_p1    = byte_cnt_q + CNT_ONE;
    assign cnt_p2    = byte_cnt_q + CNT_TWO;
    assign hdr_nxt   = hdr_idx_q + 2'd1;
    assign frame_end = (baud_cnt_q == 16'd0) && (bit_idx_q == 4'd9);

    // Frame sequencing and prefetch scheduling
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        byte_cnt_d = byte_cnt_q;
        base_d     = base_q;
        len_d      = len_q;
        load       = 1'b0;
        load_byte  = 8'h00;
        issue_rd   = 1'b0;
        rd_idx     = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    len_d      = len_i;
                    byte_cnt_d = '0;
                    hdr_idx_d  = 2'd0;
                    state_d    = S_HDR;
                    load       = 1'b1;
                    load_byte  = hdr_byte(2'd0);
                end
            end
            S_HDR: begin
                if (frame_end) begin
                    if (hdr_idx_q != 2'd3) begin
                        hdr_idx_d = hdr_nxt;
                        load      = 1'b1;
                        load_byte = hdr_byte(hdr_nxt);
                        // Fetch byte 0 while the last header byte is on the wire
                        if (hdr_nxt == 2'd3 && len_q != '0) begin
                            issue_rd = 1'b1;
                            rd_idx   = '0;
                        end
                    end else if (len_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_DATA;
                        byte_cnt_d = '0;
                        load       = 1'b1;
                        load_byte  = pre_q;
                        if (len_ext > CNT_ONE) begin
                            issue_rd = 1'b1;
                            rd_idx   = CNT_ONE;
                        end
                    end
                end
            end
            S_DATA: begin
                if (frame_end) begin
                    if (cnt_p1 == len_ext) begin
                        state_d = S_DONE;
                    end else begin
                        byte_cnt_d = cnt_p1;
                        load       = 1'b1;
                        load_byte  = pre_q;
                        if (cnt_p2 < len_ext) begin
                            issue_rd = 1'b1;
                            rd_idx   = cnt_p2;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bit serializer and memory read port
    always_comb begin
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        re_d       = 1'b0;
        re_dly_d   = re_q;
        addr_d     = addr_q;
        pre_d      = pre_q;

        if (re_dly_q) begin
            pre_d = mem_din_i;
        end
        if (issue_rd) begin
            re_d   = 1'b1;
            addr_d = base_q + rd_idx[ADDR_W-1:0];
        end

        if (load) begin
            tx_d       = 1'b0;
            shift_d    = {1'b1, load_byte};
            bit_idx_d  = 4'd0;
            div_d      = eff_div;
            baud_cnt_d = eff_div - 16'd1;
        end else if (state_q == S_HDR || state_q == S_DATA) begin
            if (frame_end) begin
                tx_d = 1'b1;    // last stop bit done, line returns to idle
            end else if (baud_cnt_q == 16'd0) begin
                tx_d       = shift_q[0];
                shift_d    = {1'b1, shift_q[8:1]};
                bit_idx_d  = bit_idx_q + 4'd1;
                baud_cnt_d = div_q - 16'd1;
            end else begin
                baud_cnt_d = baud_cnt_q - 16'd1;
            end
        end else begin
            tx_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            hdr_idx_q  <= 2'd0;
            byte_cnt_q <= '0;
            base_q     <= '0;
            len_q      <= '0;
            div_q      <= 16'd1;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 4'd0;
            shift_q    <= 9'h1FF;
            tx_q       <= 1'b1;
            pre_q      <= 8'h00;
            re_q       <= 1'b0;
            re_dly_q   <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            hdr_idx_q  <= hdr_idx_d;
            byte_cnt_q <= byte_cnt_d;
            base_q     <= base_d;
            len_q      <= len_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            pre_q      <= pre_d;
            re_q       <= re_d;
            re_dly_q   <= re_dly_d;
            addr_q     <= addr_d;
        end
    end

    assign tx_o           = tx_q;
    assign mem_re_o       = re_q;
    assign mem_addr_o     = addr_q;
    assign busy_o         = (state_q == S_HDR) || (state_q == S_DATA);
    assign disable_core_n = ~busy_o;
    assign done_o         = (state_q == S_DONE);

endmodule

// File: tb/tb_mystic_main_mem_tx.sv
// Directed bench for the UART memory-dump transmitter.
// Decodes tx_o at mid-bit, checks transfer length, read addresses and status outputs.
// Synchronous RAM model answers mem_re_o one cycle later.
module tb_mystic_main_mem_tx;

    localparam int          AW  = 18;
    localparam logic [31:0] HDR = 32'hABCD1234;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW-1:0] len_i;
    logic [15:0]   baud_div;
    logic [7:0]    mem_din_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_re_o;
    logic          tx_o;
    logic          disable_core_n;
    logic          busy_o;
    logic          done_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:(1<<AW)-1];

    mystic_main_mem_tx dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .len_i          (len_i),
        .baud_div       (baud_div),
        .mem_din_i      (mem_din_i),
        .mem_addr_o     (mem_addr_o),
        .mem_re_o       (mem_re_o),
        .tx_o           (tx_o),
        .disable_core_n (disable_core_n),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_re_o) mem_din_i <= mem[mem_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer; glitch >= 0 pulses start_i (base 0) at that busy cycle.
    task automatic run_xfer(input string name, input logic [AW-1:0] base,
                            input logic [AW-1:0] len, input logic [15:0] bd,
                            input int glitch);
        logic [7:0]    exp_b[$];
        logic [AW-1:0] addrs[$];
        logic          tx_s[$];
        logic [AW-1:0] a;
        logic [7:0]    got;
        int eff, n, bound, dcn_bad, done_cnt, frm_bad, idx;
        eff = (bd == 16'd0) ? 1 : int'(bd);
        for (int i = 0; i < 4; i++) exp_b.push_back(HDR[31-8*i -: 8]);
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i);
            exp_b.push_back(mem[a]);
        end
        bound = (4 + int'(len)) * 10 * eff + 50;

        @(negedge clk_i);
        base_addr_i = base;
        len_i       = len;
        baud_div    = bd;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({name, "_first_tx"}, {31'd0, tx_o}, 32'd0);

        n = 0; dcn_bad = 0; done_cnt = 0;
        while (busy_o && n < bound) begin
            tx_s.push_back(tx_o);
            if (disable_core_n !== 1'b0) dcn_bad++;
            if (done_o) done_cnt++;
            if (mem_re_o) addrs.push_back(mem_addr_o);
            if (n == glitch)     begin start_i = 1'b1; base_addr_i = '0; end
            if (n == glitch + 1) start_i = 1'b0;
            n++;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        chk({name, "_cycles"}, n, (4 + int'(len)) * 10 * eff);
        chk({name, "_dcn_low"}, dcn_bad, 0);
        chk({name, "_done_pulse"}, {31'd0, done_o}, 32'd1);
        chk({name, "_dcn_after"}, {31'd0, disable_core_n}, 32'd1);
        chk({name, "_nreads"}, addrs.size(), int'(len));
        for (int i = 0; i < addrs.size() && i < int'(len); i++) begin
            a = base + AW'(i);
            chk($sformatf("%s_addr%0d", name, i), 32'(addrs[i]), 32'(a));
        end

        frm_bad = 0;
        for (int f = 0; f < exp_b.size(); f++) begin
            got = 8'h00;
            for (int k = 0; k < 10; k++) begin
                idx = f * 10 * eff + k * eff + eff / 2;
                if (idx >= tx_s.size()) begin
                    frm_bad++;
                end else if (k == 0) begin
                    if (tx_s[idx] !== 1'b0) frm_bad++;
                end else if (k == 9) begin
                    if (tx_s[idx] !== 1'b1) frm_bad++;
                end else begin
                    got[k-1] = tx_s[idx];
                end
            end
            chk($sformatf("%s_byte%0d", name, f), 32'(got), 32'(exp_b[f]));
        end
        chk({name, "_framing"}, frm_bad, 0);

        @(negedge clk_i);
        chk({name, "_done_1cyc"}, {31'd0, done_o}, 32'd0);
        chk({name, "_idle_tx"}, {31'd0, tx_o}, 32'd1);
        chk({name, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[18'h00010] = 8'h55;
        mem[18'h00011] = 8'hA3;
        mem[18'h3FFFF] = 8'h96;
        mem[18'h00000] = 8'hC3;
        mem[18'h00001] = 8'h7E;

        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0;
        baud_div = 16'd4; mem_din_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tx",   {31'd0, tx_o}, 32'd1);
        chk("rst_dcn",  {31'd0, disable_core_n}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_re",   {31'd0, mem_re_o}, 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_xfer("t1", 18'h00010, 18'd2, 16'd4, -1);
        run_xfer("t2", 18'h00010, 18'd0, 16'd2, -1);
        run_xfer("t3", 18'h3FFFF, 18'd3, 16'd3, -1);
        run_xfer("t4", 18'h00010, 18'd2, 16'd4, 100);
        run_xfer("t6a", 18'h00010, 18'd2, 16'd0, -1);
        run_xfer("t6b", 18'h3FFFF, 18'd3, 16'd1, -1);

        // Reset in the middle of data frame 0 (header ends after 160 cycles)
        @(negedge clk_i);
        base_addr_i = 18'h00010; len_i = 18'd2; baud_div = 16'd4; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (175) @(negedge clk_i);
        chk("t5_busy_before", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t5_tx",   {31'd0, tx_o}, 32'd1);
        chk("t5_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_dcn",  {31'd0, disable_core_n}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_xfer("t5_restart", 18'h00010, 18'd2, 16'd2, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
